// File: rtl/aes_key_expand.sv
// AES-128 key schedule: emits round keys 0..NR one per valid/ready handshake.
// The S-box is computed as GF(2^8) inversion followed by the FIPS-197 affine map.

module aes_Sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    logic [7:0] inv;

    assign inv = ginv(a);
    assign y   = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
endmodule

module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         start,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_round,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [3:0] LAST = 4'(NR);

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       state;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  temp;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    assign {w0, w1, w2, w3} = round_key;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_Sbox u_sbox (
            .a(rot_w3[8*b +: 8]),
            .y(sub_w3[8*b +: 8])
        );
    end

    assign temp     = sub_w3 ^ {rcon(rk_round + 4'd1), 24'h000000};
    assign n0       = w0 ^ temp;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
            round_key <= '0;
            rk_round  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= EMIT;
                        round_key <= key_in;
                        rk_round  <= '0;
                        busy      <= 1'b1;
                        rk_valid  <= 1'b1;
                    end
                end
                EMIT: begin
                    // rk_valid is always high here, so rk_ready alone is the accept.
                    if (rk_ready) begin
                        if (rk_round == LAST) begin
                            state    <= IDLE;
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            round_key <= next_key;
                            rk_round  <= rk_round + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a word-array FIPS-197 key schedule model.

module tb_aes_key_expand;
    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         start;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_round;
    logic         done;

    aes_key_expand #(.NR(NR)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .start(start), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
        .rk_round(rk_round), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] model_rk [0:NR];
    logic [127:0] obs_rk   [0:NR];

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;
    vec_t tbl [0:1];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Carry-less product then reduction by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] b;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gm(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                   ^ inv[(i + 7) % 8] ^ c[i];
        return b;
    endfunction

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [0:4*NR+3];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t  = t ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [127:0] key);
        key_in = key;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    // Expects key 0 on the outputs; ends in the cycle where done should be high.
    task automatic run_body(input int stall_at, input int stall_len, input int glitch_at,
                            input logic [127:0] glitch_key);
        logic [127:0] held_key;
        logic [3:0]   held_round;
        for (int r = 0; r <= NR; r++) begin
            chk($sformatf("rk_valid r%0d", r), 128'(rk_valid), 128'd1);
            chk($sformatf("rk_round r%0d", r), 128'(rk_round), 128'(r));
            chk($sformatf("round_key r%0d", r), round_key, model_rk[r]);
            chk($sformatf("busy r%0d", r), 128'(busy), 128'd1);
            chk($sformatf("done r%0d", r), 128'(done), 128'd0);
            obs_rk[r] = round_key;
            if (r == stall_at) begin
                held_key   = round_key;
                held_round = rk_round;
                rk_ready   = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk($sformatf("stall key r%0d s%0d", r, s), round_key, held_key);
                    chk($sformatf("stall round r%0d s%0d", r, s), 128'(rk_round), 128'(held_round));
                    chk($sformatf("stall valid r%0d s%0d", r, s), 128'(rk_valid), 128'd1);
                end
                rk_ready = 1'b1;
            end
            if (r == glitch_at) begin
                start  = 1'b1;
                key_in = glitch_key;
            end
            step();
            start = 1'b0;
        end
        chk("done pulse", 128'(done), 128'd1);
        chk("end rk_valid", 128'(rk_valid), 128'd0);
        chk("end busy", 128'(busy), 128'd0);
        chk("end rk_round", 128'(rk_round), 128'(NR));
        chk("end round_key", round_key, model_rk[NR]);
    endtask

    task automatic after_done();
        step();
        chk("done width", 128'(done), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] fips;
        logic [127:0] rkey;
        fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tbl[0] = '{fips, 128'ha0fafe1788542cb123a339392a6c7605,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[1] = '{128'h0, 128'h62636363626363636263636362636363,
                   128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

        rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key_in = '0;
        step(); step();
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset rk_valid", 128'(rk_valid), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset round_key", round_key, 128'd0);
        chk("reset rk_round", 128'(rk_round), 128'd0);
        rst = 1'b0;
        step();
        chk("idle rk_valid", 128'(rk_valid), 128'd0);

        // Known-answer vectors, unstalled.
        for (int v = 0; v < 2; v++) begin
            compute_model(tbl[v].key);
            issue_start(tbl[v].key);
            run_body(-1, 0, -1, '0);
            chk($sformatf("kat%0d key0", v), obs_rk[0], tbl[v].key);
            chk($sformatf("kat%0d rk1", v), obs_rk[1], tbl[v].rk1);
            chk($sformatf("kat%0d rk10", v), obs_rk[NR], tbl[v].rk10);
            after_done();
        end

        // Backpressure at round 3 for 5 cycles.
        compute_model(fips);
        issue_start(fips);
        run_body(3, 5, -1, '0);
        chk("bp rk10", obs_rk[NR], tbl[0].rk10);
        after_done();

        // Start with a different key during EMIT is ignored.
        issue_start(fips);
        run_body(-1, 0, 2, 128'hdeadbeef0123456789abcdeffedcba98);
        chk("ign rk10", obs_rk[NR], tbl[0].rk10);
        after_done();

        // Reset at round 5 aborts without done.
        issue_start(fips);
        for (int s = 0; s < 5; s++) step();
        chk("pre-rst rk_round", 128'(rk_round), 128'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort rk_valid", 128'(rk_valid), 128'd0);
        chk("abort busy", 128'(busy), 128'd0);
        chk("abort done", 128'(done), 128'd0);
        step();
        chk("abort done later", 128'(done), 128'd0);
        chk("abort idle valid", 128'(rk_valid), 128'd0);
        issue_start(fips);
        run_body(-1, 0, -1, '0);
        after_done();

        // Back-to-back: start raised in the done cycle.
        issue_start(fips);
        run_body(-1, 0, -1, '0);
        rkey = {$urandom, $urandom, $urandom, $urandom};
        compute_model(rkey);
        issue_start(rkey);
        run_body(-1, 0, -1, '0);
        after_done();

        // Random keys with random stalls and ignored starts.
        for (int n = 0; n < 6; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            compute_model(rkey);
            issue_start(rkey);
            run_body(int'($urandom_range(0, NR)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, NR - 1)), {$urandom, $urandom, $urandom, $urandom});
            after_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
